// File: rtl/syn_accum_seq.sv
// syn_accum_seq: byte-serial burst accumulator time-sharing one cla8 adder.
// Define SYN_ACCUM_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);
  logic [7:0] g, p;
  logic [8:0] c;
  assign g = a & b;
  assign p = a ^ b;
  // each carry is a flat sum of generate terms gated by the propagates above them
  always_comb begin
    logic t, pp;
    c = '0;
    for (int i = 0; i <= 8; i++) begin
      t = 1'b0;
      pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        t = t | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i] = t | (pp & ci);
    end
  end
  assign s = p ^ c[7:0];
  assign co = c[8];
endmodule

module syn_accum_seq #(
  parameter int CNT_W = 10,
  parameter int ACC_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       len,
  input  logic                   w_valid,
  input  logic [7:0]             w_data,
  output logic                   w_ready,
  output logic                   busy,
  output logic                   done,
  output logic [8*ACC_BYTES-1:0] sum,
  output logic                   ovf
);
  localparam int IDX_W = ACC_BYTES > 1 ? $clog2(ACC_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_BYTES - 1);
  typedef enum logic [1:0] {IDLE, FETCH, ADD, DONE} state_t;
  state_t state, nxt;
  logic [8*ACC_BYTES-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0] op, s;
  logic cry, co, last;
  cla8 u_add (
    .a(acc[{idx, 3'b000} +: 8]),
    .b(idx == '0 ? op : 8'h00),
    .ci(cry),
    .s(s),
    .co(co)
  );
  assign last = idx == LAST_IDX;
  assign w_ready = state == FETCH;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    acc_nxt = acc;
    acc_nxt[{idx, 3'b000} +: 8] = s;
`ifdef SYN_ACCUM_SAT_EN
    if (last && co) acc_nxt = '1;
`else
`endif
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && start) nxt = (len != '0) ? FETCH : DONE;
    if (state == FETCH && w_valid) nxt = ADD;
    if (state == ADD && last) nxt = (cnt == CNT_W'(1)) ? DONE : FETCH;
    if (state == DONE) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      idx <= '0;
      op <= '0;
      cry <= 1'b0;
      sum <= '0;
      ovf <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= len;
        if (len == '0) sum <= '0;
      end
      if (state == FETCH && w_valid) begin
        op <= w_data;
        idx <= '0;
        cry <= 1'b0;
      end
      if (state == ADD) begin
        acc <= acc_nxt;
        cry <= co;
        idx <= last ? '0 : idx + 1'b1;
        if (last) cnt <= cnt - 1'b1;
        if (last && co) ovf <= 1'b1;
        if (last && cnt == CNT_W'(1)) sum <= acc_nxt;
      end
    end
  end
endmodule

// File: tb/tb_syn_accum_seq.sv
// tb_syn_accum_seq: directed burst vectors plus reset-abort sequence for syn_accum_seq.
module tb_syn_accum_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, w_valid = 1'b0;
  logic [9:0] len = '0;
  logic [7:0] w_data = '0;
  logic w_ready, busy, done, ovf;
  logic [15:0] sum, last_sum;
  int tests = 0, fails = 0;

  typedef struct packed {
    int n;
    logic [3:0][7:0] w;
    int gap;
    logic poke;
    logic [15:0] s;
    logic o;
    int cyc;
  } vec_t;
  vec_t v [6];

  syn_accum_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .w_valid(w_valid),
    .w_data(w_data), .w_ready(w_ready), .busy(busy), .done(done), .sum(sum), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run(input vec_t t, input string name);
    int cyc, dcyc, dcnt, rdy, k, stall;
    logic hold_ok;
    logic [15:0] gs;
    logic go;
    dcyc = 0; dcnt = 0; rdy = 0; k = 0; stall = 0; hold_ok = 1'b1; gs = '0; go = 1'b0;
    start = 1'b1;
    len = t.n[9:0];
    w_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 2000 && !(dcyc > 0 && cyc > dcyc + 2)) begin
      if (done) begin
        dcnt++;
        if (dcyc == 0) begin dcyc = cyc; gs = sum; go = ovf; end
      end else if (dcyc == 0 && sum !== last_sum) hold_ok = 1'b0;
      if (w_ready) rdy++;
      start = t.poke && cyc == 3;
      len = (t.poke && cyc == 3) ? 10'd1 : t.n[9:0];
      if (w_ready) begin
        if (stall < t.gap) begin
          w_valid = 1'b0;
          stall++;
        end else begin
          w_valid = 1'b1;
          w_data = t.w[k % 4];
          k++;
          stall = 0;
        end
      end else begin
        w_valid = (t.gap == 0);
        w_data = 8'h5A;
      end
      @(negedge clk);
      cyc++;
    end
    w_valid = 1'b0;
    start = 1'b0;
    chk({name, " done_cycle"}, dcyc, t.cyc);
    chk({name, " sum"}, {16'h0, gs}, {16'h0, t.s});
    chk({name, " ovf"}, {31'h0, go}, {31'h0, t.o});
    chk({name, " ready_cycles"}, rdy, t.n * (1 + t.gap));
    chk({name, " done_pulses"}, dcnt, 1);
    chk({name, " sum_hidden_midburst"}, {31'h0, hold_ok}, 32'h1);
    chk({name, " idle_hold"}, {15'h0, busy, sum}, {16'h0, t.s});
    last_sum = t.s;
  endtask

  initial begin
    vec_t r;
    v[0] = '{n: 3, w: {8'h00, 8'd30, 8'd20, 8'd10}, gap: 0, poke: 1'b0, s: 16'd60, o: 1'b0, cyc: 10};
    v[1] = '{n: 0, w: '0, gap: 0, poke: 1'b0, s: 16'd0, o: 1'b0, cyc: 1};
    v[2] = '{n: 2, w: {8'h00, 8'h00, 8'h01, 8'hFF}, gap: 0, poke: 1'b0, s: 16'h0100, o: 1'b0, cyc: 7};
`ifdef SYN_ACCUM_SAT_EN
    v[3] = '{n: 300, w: {4{8'hFF}}, gap: 0, poke: 1'b0, s: 16'hFFFF, o: 1'b1, cyc: 901};
`else
    v[3] = '{n: 300, w: {4{8'hFF}}, gap: 0, poke: 1'b0, s: 16'h2AD4, o: 1'b1, cyc: 901};
`endif
    v[4] = '{n: 4, w: {8'd4, 8'd3, 8'd2, 8'd1}, gap: 0, poke: 1'b0, s: 16'd10, o: 1'b0, cyc: 13};
    v[5] = '{n: 2, w: {8'h00, 8'h00, 8'd200, 8'd100}, gap: 5, poke: 1'b1, s: 16'd300, o: 1'b0, cyc: 17};
    last_sum = '0;
    #2;
    chk("reset_outputs", {11'h0, w_ready, busy, done, ovf, sum}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) run(v[i], $sformatf("vec%0d", i));
    start = 1'b1;
    len = 10'd4;
    @(negedge clk);
    start = 1'b0;
    w_valid = 1'b1;
    w_data = 8'd9;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_add_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", {11'h0, w_ready, busy, done, ovf, sum}, 32'h0);
    w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {30'h0, done, busy}, 32'h0);
    end
    rst_n = 1'b1;
    last_sum = '0;
    @(negedge clk);
    r = '{n: 1, w: {8'h00, 8'h00, 8'h00, 8'd7}, gap: 0, poke: 1'b0, s: 16'd7, o: 1'b0, cyc: 4};
    run(r, "after_abort");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/syn_accum_seq.md
Name: syn_accum_seq

Overview:
Multi-cycle sequencer that time-shares one 8-bit carry-lookahead adder (team cla8) to accumulate a burst of unsigned 8-bit synaptic weights into a wide membrane-potential sum. Each operand is added byte-serially, low byte first, with the adder carry registered between passes. Sits between the spike/weight fetch stage and the neuron update stage. Replaces wide multi-operand adder trees with one shared adder.

Parameters:
CNT_W, 10, width of burst length / operand counter (max burst 2^CNT_W-1)
ACC_BYTES, 2, accumulator width in bytes; accumulator is 8*ACC_BYTES bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin burst; sampled only in IDLE
len  input  CNT_W  number of operands in burst, sampled with start
w_valid  input  1  weight operand valid
w_data  input  8  unsigned weight operand
w_ready  output  1  sequencer accepts operand this cycle
busy  output  1  burst in progress (state != IDLE)
done  output  1  one-cycle pulse, sum/ovf valid
sum  output  8*ACC_BYTES  accumulated result, held until next accepted start
ovf  output  1  sticky: accumulator overflowed during the burst

Behaviour:
- Reset (async assert, sync-released by design): state=IDLE; w_ready=0, busy=0, done=0, sum=0, ovf=0; accumulator, counter, byte index, carry reg all 0.
- States: IDLE, FETCH, ADD, DONE.
- IDLE: w_ready=0. start=1 and len!=0 -> acc=0, ovf=0, cnt=len, go FETCH. start=1 and len==0 -> sum=0, ovf=0, go DONE. start ignored in every other state.
- FETCH: w_ready=1 (combinational from state). w_valid&w_ready -> latch w_data into op reg, byte idx=0, carry reg=0, go ADD. No accept -> stay, no timeout.
- ADD: one adder pass per cycle: a=acc byte[idx], b=(idx==0 ? op : 8'h00), ci=carry reg; write s back to acc byte[idx], carry reg=co, idx++.
- After pass idx=ACC_BYTES-1: if co=1, set ovf (sticky); acc wraps modulo 2^(8*ACC_BYTES). cnt--. cnt reaches 0 -> go DONE, else FETCH.
- DONE: done=1 for exactly one cycle, sum<=acc registered at entry to DONE, then IDLE. start in DONE ignored.
- Timing, zero-stall source: start at cycle 0 -> done asserted at cycle len*(1+ACC_BYTES)+1. len==0: done at cycle 1.
- w_valid deasserted in FETCH adds stall cycles 1:1; no other stall sources.
- w_data must be stable only in the accepting cycle; w_valid outside FETCH has no effect.
- sum not updated mid-burst; intermediate acc not visible.
- rst_n asserted mid-burst: immediate abort to reset values, no done pulse; partial sum discarded.
- Exactly one cla8 instance; no other adders on the accumulation path (counter decrement excluded).

Optional Feature:
SYN_ACCUM_SAT_EN
- Defined: on final-byte carry-out, acc forced to all-ones and ovf set; later operands still consumed (handshake and timing unchanged), acc remains all-ones.
- Undefined: acc wraps modulo 2^(8*ACC_BYTES); ovf still set.

Test Plan:
- Basic: len=3, weights 10,20,30, w_valid held 1 -> done at cycle 10, sum=16'd60, ovf=0, w_ready high exactly 3 cycles.
- Byte carry: len=2, weights 8'hFF,8'h01 -> sum=16'h0100, ovf=0.
- Overflow: len=300, all 8'hFF -> wrap build sum=16'h2AD4, ovf=1; SYN_ACCUM_SAT_EN build sum=16'hFFFF, ovf=1; both done at cycle 901.
- Zero length: start with len=0 after prior sum=60 -> done at cycle 1, sum=0, ovf=0, w_ready never asserted.
- Stalls/ignored start: len=2, w_valid low 5 cycles before each operand, start pulsed while busy -> done at cycle 17, sum correct, no second burst.
- Reset mid-burst: rst_n low during 2nd ADD pass of a len=4 burst -> all outputs 0 same cycle, no done; a new burst after release (len=1, weight 7) gives sum=7.
